// File: rtl/flappy_pkg.sv
// Shared Flappy geometry, state encoding, LFSR seed/taps and initial pipe gaps.
// The VGA compositor imports the same package so both sides agree on geometry.
package flappy_pkg;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BIRD_X       = 100;
  localparam int BIRD_SIZE    = 30;
  localparam int BIRD_Y0      = 225;
  localparam int PIPE_W       = 50;
  localparam int GAP_H        = 100;
  localparam int NUM_PIPES    = 4;
  localparam int PIPE_SPACING = 160;
  localparam int GAP_MIN      = 40;
  localparam int GRAVITY      = 1;
  localparam int FLAP_VEL     = -8;
  localparam int MAX_FALL     = 8;
  localparam int SCROLL       = 1;

  localparam int X_W = 11;
  localparam int Y_W = 9;
  localparam int V_W = 6;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CHECK = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  function automatic logic [Y_W-1:0] init_gap(input int i);
    case (i)
      0:       return Y_W'(100);
      1:       return Y_W'(300);
      2:       return Y_W'(180);
      3:       return Y_W'(240);
      default: return Y_W'(100);
    endcase
  endfunction

  function automatic logic [X_W-1:0] init_px(input int i);
    return X_W'(SCREEN_W + i * PIPE_SPACING);
  endfunction
endpackage

// File: rtl/flappy_game_engine_if.sv
// Game-engine bus: frame/flap inputs and the frame-stable positions fed to the compositor.
interface flappy_game_engine_if;
  import flappy_pkg::*;

  logic                     frame_tick;
  logic                     flap;
  logic [Y_W-1:0]           bird_y;
  logic [NUM_PIPES*X_W-1:0] pipe_x;
  logic [NUM_PIPES*Y_W-1:0] pipe_gap_y;
  logic [7:0]               score;
  logic                     game_over;
  logic [1:0]               state;

  modport master (
    output frame_tick, flap,
    input  bird_y, pipe_x, pipe_gap_y, score, game_over, state
  );

  modport slave (
    input  frame_tick, flap,
    output bird_y, pipe_x, pipe_gap_y, score, game_over, state
  );
endinterface

// File: rtl/flappy_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick new pipe gap heights.
module flappy_lfsr8
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/flappy_game_engine.sv
// Flappy game-state engine: bird physics, pipe scroll, scoring and collision,
// advancing once per frame_tick with all outputs registered.
module flappy_game_engine
  import flappy_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  flappy_game_engine_if.slave bus
);
  localparam logic signed [V_W-1:0] V_FLAP   = V_W'(FLAP_VEL);
  localparam logic signed [V_W-1:0] V_MAX    = V_W'(MAX_FALL);
  localparam logic signed [V_W-1:0] V_GRAV   = V_W'(GRAVITY);
  localparam logic [X_W-1:0]        X_RELOAD = X_W'(NUM_PIPES * PIPE_SPACING - SCROLL);
  localparam logic [X_W-1:0]        X_PASS   = X_W'(BIRD_X - PIPE_W - 1);

  state_t                        state_q, state_d;
  logic [Y_W-1:0]                bird_y_q, bird_y_d;
  logic signed [V_W-1:0]         vel_q, vel_d, vel_tick;
  logic signed [X_W-1:0]         y_tick;
  logic [7:0]                    score_q, score_d;
  logic                          go_q, go_d;
  logic                          flap_prev, pend_q, pend_d, flap_edge;
  logic [NUM_PIPES-1:0][X_W-1:0] px_q, px_d, px_tick;
  logic [NUM_PIPES-1:0][Y_W-1:0] gap_q, gap_d, gap_tick;
  logic [NUM_PIPES-1:0]          pass, pipe_hit;
  logic                          floor_hit;
  logic [7:0]                    lfsr;

  flappy_lfsr8 u_lfsr (.clk(clk), .reset(reset), .q(lfsr));

  assign flap_edge = bus.flap & ~flap_prev;

  // A pending flap and a fresh edge on the tick cycle are treated alike
  assign vel_tick = (pend_q | flap_edge) ? V_FLAP :
                    (vel_q >= V_MAX)     ? V_MAX  : vel_q + V_GRAV;
  assign y_tick   = $signed({2'b00, bird_y_q}) +
                    $signed({{(X_W-V_W){vel_tick[V_W-1]}}, vel_tick});

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    assign px_tick[i]  = (px_q[i] == '0) ? X_RELOAD : px_q[i] - X_W'(SCROLL);
    assign gap_tick[i] = (px_q[i] == '0) ? Y_W'(GAP_MIN) + {1'b0, lfsr} : gap_q[i];
    assign pass[i]     = (px_tick[i] == X_PASS);
    // Inclusive x-overlap of bird and pipe, then bird not fully inside the opening
    assign pipe_hit[i] = ({1'b0, px_q[i]} <= 12'(BIRD_X + BIRD_SIZE)) &&
                         ({1'b0, px_q[i]} + 12'(PIPE_W) >= 12'(BIRD_X)) &&
                         (({1'b0, bird_y_q} < {1'b0, gap_q[i]}) ||
                          ({1'b0, bird_y_q} + 10'(BIRD_SIZE) > {1'b0, gap_q[i]} + 10'(GAP_H)));
  end

  assign floor_hit = ({1'b0, bird_y_q} + 10'(BIRD_SIZE)) >= 10'(SCREEN_H);

  always_comb begin
    state_d  = state_q;
    bird_y_d = bird_y_q;
    vel_d    = vel_q;
    score_d  = score_q;
    go_d     = go_q;
    pend_d   = pend_q | flap_edge;
    px_d     = px_q;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: if (flap_edge) begin
        state_d = S_PLAY;
        vel_d   = V_FLAP;
        pend_d  = 1'b0;
      end
      S_PLAY: if (bus.frame_tick) begin
        state_d = S_CHECK;
        pend_d  = 1'b0;
        px_d    = px_tick;
        gap_d   = gap_tick;
        if (y_tick < 0) begin
          bird_y_d = '0;
          vel_d    = '0;
        end else begin
          bird_y_d = y_tick[Y_W-1:0];
          vel_d    = vel_tick;
        end
        if (|pass && score_q != 8'hFF) score_d = score_q + 8'd1;
      end
      S_CHECK: begin
        if (floor_hit || |pipe_hit) begin
          state_d = S_DEAD;
          go_d    = 1'b1;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_DEAD: if (flap_edge) begin
        state_d  = S_IDLE;
        bird_y_d = Y_W'(BIRD_Y0);
        vel_d    = '0;
        score_d  = '0;
        go_d     = 1'b0;
        pend_d   = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
          px_d[i]  = init_px(i);
          gap_d[i] = init_gap(i);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bird_y_q  <= Y_W'(BIRD_Y0);
      vel_q     <= '0;
      score_q   <= '0;
      go_q      <= 1'b0;
      flap_prev <= 1'b0;
      pend_q    <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_q[i]  <= init_px(i);
        gap_q[i] <= init_gap(i);
      end
    end else begin
      state_q   <= state_d;
      bird_y_q  <= bird_y_d;
      vel_q     <= vel_d;
      score_q   <= score_d;
      go_q      <= go_d;
      flap_prev <= bus.flap;
      pend_q    <= pend_d;
      px_q      <= px_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.bird_y     = bird_y_q;
  assign bus.pipe_x     = px_q;
  assign bus.pipe_gap_y = gap_q;
  assign bus.score      = score_q;
  assign bus.game_over  = go_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_flappy_game_engine.sv
// Directed + randomized bench for flappy_game_engine against a frame-level game model.
module tb_flappy_game_engine;
  import flappy_pkg::*;

  logic clk = 1'b0;
  logic reset;
  flappy_game_engine_if bus();

  flappy_game_engine dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Game model: mode 0 idle, 1 play, 2 check, 3 dead
  int m_mode, m_y, m_vel, m_pend, m_prev, m_score, m_go, m_lfsr;
  int m_px [NUM_PIPES];
  int m_gap[NUM_PIPES];
  int gap_tab[4] = '{100, 300, 180, 240};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input bit with_lfsr);
    m_mode = 0; m_y = 225; m_vel = 0; m_pend = 0; m_score = 0; m_go = 0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      m_px[i]  = 640 + 160 * i;
      m_gap[i] = (i < 4) ? gap_tab[i] : 100;
    end
    if (with_lfsr) begin
      m_prev = 0;
      m_lfsr = 8'hA5;
    end
  endtask

  function automatic bit model_collide();
    bit c = (m_y + 30 >= 480);
    for (int i = 0; i < NUM_PIPES; i++)
      if (!(m_px[i] > 130 || m_px[i] + 50 < 100) &&
          (m_y < m_gap[i] || m_y + 30 > m_gap[i] + 100))
        c = 1;
    return c;
  endfunction

  task automatic model_step(input bit tick, input bit fl);
    bit e = fl && !m_prev;
    bit passed = 0;
    case (m_mode)
      0: if (e) begin m_mode = 1; m_vel = -8; m_pend = 0; end
      1: if (tick) begin
        if (m_pend || e) m_vel = -8;
        else             m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
        m_pend = 0;
        m_y = m_y + m_vel;
        if (m_y < 0) begin m_y = 0; m_vel = 0; end
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (m_px[i] == 0) begin m_px[i] = 639; m_gap[i] = 40 + m_lfsr; end
          else m_px[i] = m_px[i] - 1;
          if (m_px[i] == 49) passed = 1;
        end
        if (passed && m_score < 255) m_score++;
        m_mode = 2;
      end else if (e) m_pend = 1;
      2: begin
        if (e) m_pend = 1;
        if (model_collide()) begin m_mode = 3; m_go = 1; end
        else m_mode = 1;
      end
      default: if (e) model_reset(0);
    endcase
    m_prev = fl;
    m_lfsr = ((m_lfsr << 1) & 255) |
             (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
  endtask

  task automatic check_all();
    chk("state", bus.state, m_mode);
    chk("bird_y", bus.bird_y, m_y);
    chk("score", bus.score, m_score);
    chk("game_over", bus.game_over, m_go);
    for (int i = 0; i < NUM_PIPES; i++) begin
      chk($sformatf("pipe_x%0d", i), bus.pipe_x[11*i +: 11], m_px[i]);
      chk($sformatf("gap_y%0d", i), bus.pipe_gap_y[9*i +: 9], m_gap[i]);
    end
  endtask

  task automatic cycle(input bit tick, input bit fl);
    bus.frame_tick = tick;
    bus.flap       = fl;
    @(posedge clk);
    model_step(tick, fl);
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"}, bus.state, 0);
    chk({pfx, "_bird_y"}, bus.bird_y, 225);
    chk({pfx, "_score"}, bus.score, 0);
    chk({pfx, "_go"}, bus.game_over, 0);
    for (int i = 0; i < NUM_PIPES; i++) begin
      chk($sformatf("%s_px%0d", pfx, i), bus.pipe_x[11*i +: 11], 640 + 160 * i);
      chk($sformatf("%s_gap%0d", pfx, i), bus.pipe_gap_y[9*i +: 9], gap_tab[i]);
    end
  endtask

  initial begin
    int exp_y[3] = '{218, 212, 207};
    int t, k, idle, pj, yd;
    logic [8:0] g;
    bit fl, calm;

    reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.flap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    #3 reset = 1'b0;
    model_reset(1);

    // IDLE ignores ticks; flap edge starts play with no motion
    repeat (4) cycle(1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b0, 1'b1);
    chk("start_state", bus.state, 1);
    chk("start_no_motion", bus.bird_y, 225);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      chk("tick_to_check", bus.state, 2);
      chk("rise_y", bus.bird_y, exp_y[i]);
      cycle(1'b0, 1'b0);
      chk("check_one_cycle", bus.state, 1);
    end
    cycle(1'b1, 1'b1);
    chk("flap_with_tick_y", bus.bird_y, 199);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("after_flap_y", bus.bird_y, 192);
    cycle(1'b0, 1'b0);

    // Free fall to the floor
    for (k = 0; k < 300; k++) begin
      cycle(1'b1, 1'b0);
      if (m_y + 30 >= 480) break;
      cycle(1'b0, 1'b0);
    end
    chk("fatal_tick_state", bus.state, 2);
    chk("fatal_tick_go", bus.game_over, 0);
    cycle(1'b0, 1'b0);
    chk("go_two_cycles", bus.game_over, 1);
    chk("dead_state", bus.state, 3);
    yd = m_y;
    repeat (4) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
    chk("dead_frozen_y", bus.bird_y, yd);
    cycle(1'b0, 1'b1);
    check_reset_values("revive");
    cycle(1'b0, 1'b0);

    // Long run: autopilot keeps the bird inside pipe0's opening, random extras elsewhere
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    t = 0;
    while (t < 645) begin
      fl = (m_y >= 140);
      cycle(1'b1, fl);
      t++;
      if (t == 590) chk("score_before_pass", bus.score, 0);
      if (t == 591) begin
        chk("score_on_pass", bus.score, 1);
        chk("pipe0_at_49", bus.pipe_x[10:0], 49);
      end
      if (t == 640) chk("pipe0_zero", bus.pipe_x[10:0], 0);
      if (t == 641) begin
        chk("pipe0_reload", bus.pipe_x[10:0], 639);
        g = bus.pipe_gap_y[8:0];
        chk("gap_in_range", 32'(g >= 9'd40 && g <= 9'd295), 1);
      end
      idle = $urandom_range(2, 4);
      calm = (m_px[0] > 200 || m_px[0] < 45);
      pj = (calm && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, idle - 2)) : -1;
      for (int j = 0; j < idle; j++)
        cycle(1'(j == 0 && $urandom_range(0, 3) == 0), 1'(j == pj));
    end
    chk("alive_after_run", bus.game_over, 0);

    // Asynchronous reset between clock edges, mid-play
    #3 reset = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #4 reset = 1'b0;
    model_reset(1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    repeat (2) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
